// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port among NUM_PORTS cache-side
// clients. One line transaction at a time: sample requests in IDLE, drive the
// registered winner to pmem in ISSUE, pulse the winner's response in DONE.
module pmem_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int LINE_WIDTH     = 128,
  parameter int FIXED_PRIORITY = 0,
  localparam int ID_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             client_read,
  input  logic [NUM_PORTS-1:0]             client_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  client_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  client_wdata,
  output logic [NUM_PORTS-1:0]             client_resp,
  output logic [LINE_WIDTH-1:0]            client_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic                             pmem_resp,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [ID_W-1:0]        last;
  logic [ID_W-1:0]        winner;
  logic                   found;
  int                     idx;
  logic [NUM_PORTS-1:0]   req;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
  logic [LINE_WIDTH-1:0]  wdata_arr [NUM_PORTS];

  assign req = client_read | client_write;

  // Unpack the flat per-client buses so the winner can be selected by index.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = client_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = client_wdata[i*LINE_WIDTH +: LINE_WIDTH];
  end

  // Winner selection: lowest index in fixed mode, otherwise the first
  // requester found searching upward (with wrap) from the last grant.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (FIXED_PRIORITY != 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[i]) winner = ID_W'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = (int'(last) + k) % NUM_PORTS;
        if (!found && req[idx]) begin
          winner = ID_W'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  // Transaction FSM with all outputs registered; a read wins over a write
  // when a client raises both, and the client is sampled only in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= ID_W'(NUM_PORTS - 1);
      grant_id     <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      client_resp  <= '0;
      client_rdata <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          client_resp <= '0;
          if (|req) begin
            grant_id     <= winner;
            pmem_address <= addr_arr[winner];
            pmem_wdata   <= wdata_arr[winner];
            pmem_read    <= client_read[winner];
            pmem_write   <= ~client_read[winner];
            if (FIXED_PRIORITY == 0) last <= winner;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (pmem_resp) begin
            if (pmem_read) client_rdata <= pmem_rdata;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            client_resp <= NUM_PORTS'(1) << grant_id;
            state       <= DONE;
          end
        end
        DONE: begin
          client_resp <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a 4-client round-robin instance driven through a
// transaction scoreboard, and a 2-client fixed-priority instance checked for
// grant order.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  // 4-port round-robin instance
  logic [3:0]   client_read, client_write, client_resp;
  logic [63:0]  client_address;
  logic [511:0] client_wdata;
  logic [127:0] client_rdata, pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp, busy;
  logic [15:0]  pmem_address;
  logic [1:0]   grant_id;
  // 2-port fixed-priority instance
  logic [1:0]   fp_read, fp_write, fp_resp;
  logic [31:0]  fp_addr;
  logic [255:0] fp_wdata;
  logic [127:0] fp_rdata_c, fp_pwdata, fp_prdata;
  logic         fp_pread, fp_pwrite, fp_presp, fp_busy;
  logic [15:0]  fp_paddr;
  logic [0:0]   fp_gid;

  pmem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .client_read(client_read), .client_write(client_write),
    .client_address(client_address), .client_wdata(client_wdata),
    .client_resp(client_resp), .client_rdata(client_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  pmem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .client_read(fp_read), .client_write(fp_write),
    .client_address(fp_addr), .client_wdata(fp_wdata),
    .client_resp(fp_resp), .client_rdata(fp_rdata_c),
    .pmem_read(fp_pread), .pmem_write(fp_pwrite),
    .pmem_address(fp_paddr), .pmem_wdata(fp_pwdata),
    .pmem_resp(fp_presp), .pmem_rdata(fp_prdata),
    .grant_id(fp_gid), .busy(fp_busy)
  );

  typedef struct {
    int           port;
    bit           rd;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } txn_t;

  txn_t         exp_q[$];
  int           fp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           pending[4];
  int           fp_pending[2];
  int           mem_cnt;
  int           mem_lat;
  bit           mem_en;
  logic [127:0] last_rd;

  localparam logic [127:0] WD2 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_data(input logic [15:0] a);
    if (a == 16'h1230) return {16{8'hA5}};
    return {8{a ^ 16'hC3C3}};
  endfunction

  task automatic push(input int p, input bit rd, input logic [15:0] a, input logic [127:0] wd);
    txn_t t;
    t.port  = p;
    t.rd    = rd;
    t.addr  = a;
    t.wdata = wd;
    t.rdata = rd ? mem_data(a) : '0;
    exp_q.push_back(t);
  endtask

  task automatic req(input int p, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [127:0] wd, input int cnt);
    client_read[p]               = rd;
    client_write[p]              = wr;
    client_address[p*16 +: 16]   = a;
    client_wdata[p*128 +: 128]   = wd;
    pending[p]                   = cnt;
  endtask

  // Scoreboard: issue-side checks against the head, response pops it.
  task automatic monitor();
    txn_t t;
    logic strobe;
    int   p;
    strobe = pmem_read | pmem_write;
    check_val("busy", 128'(busy), 128'(strobe | (|client_resp)));
    if (strobe) begin
      if (exp_q.size() == 0) check_val("unexpected_issue", 128'(strobe), 128'(0));
      else begin
        t = exp_q[0];
        check_val("grant_id", 128'(grant_id), 128'(t.port));
        check_val("pmem_read", 128'(pmem_read), 128'(t.rd));
        check_val("pmem_write", 128'(pmem_write), 128'(!t.rd));
        check_val("pmem_address", 128'(pmem_address), 128'(t.addr));
        if (!t.rd) check_val("pmem_wdata", pmem_wdata, t.wdata);
      end
    end
    if (client_resp != 4'd0) begin
      if (exp_q.size() == 0) check_val("unexpected_resp", 128'(client_resp), 128'(0));
      else begin
        t = exp_q.pop_front();
        check_val("client_resp", 128'(client_resp), 128'(4'd1 << t.port));
        if (t.rd) begin
          check_val("client_rdata", client_rdata, t.rdata);
          last_rd = t.rdata;
        end else begin
          check_val("rdata_hold", client_rdata, last_rd);
        end
      end
    end
    if (fp_resp != 2'd0) begin
      if (fp_q.size() == 0) check_val("fp_unexpected_resp", 128'(fp_resp), 128'(0));
      else begin
        p = fp_q.pop_front();
        check_val("fp_resp", 128'(fp_resp), 128'(2'd1 << p));
        check_val("fp_grant", 128'(fp_gid), 128'(p));
      end
    end
  endtask

  // Clients drop their request in the DONE cycle unless more are pending.
  task automatic drive_clients();
    for (int p = 0; p < 4; p++) begin
      if (client_resp[p]) begin
        pending[p]--;
        if (pending[p] <= 0) begin
          client_read[p]  = 1'b0;
          client_write[p] = 1'b0;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (fp_resp[p]) begin
        fp_pending[p]--;
        if (fp_pending[p] <= 0) begin
          fp_read[p]  = 1'b0;
          fp_write[p] = 1'b0;
        end
      end
    end
  endtask

  // Memory models: fixed latency for the main port, one cycle for fp.
  task automatic respond();
    if (mem_en) begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        mem_cnt   = 0;
      end else if (pmem_read | pmem_write) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_data(pmem_address);
        end
      end
    end
    if (fp_presp) fp_presp = 1'b0;
    else if (fp_pread | fp_pwrite) begin
      fp_presp  = 1'b1;
      fp_prdata = {4{32'hFEED_F00D}};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    drive_clients();
    respond();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((exp_q.size() != 0 || fp_q.size() != 0 || busy || fp_busy) && n < budget);
    if (exp_q.size() != 0 || fp_q.size() != 0 || busy || fp_busy) begin
      check_val("timeout_pending", 128'(exp_q.size() + fp_q.size()), 128'(0));
      check_val("timeout_busy", 128'({busy, fp_busy}), 128'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rr"}, 128'({pmem_read, pmem_write, busy, grant_id, client_resp, pmem_address}), 128'(0));
    check_val({tag, "_wdata"}, pmem_wdata, 128'(0));
    check_val({tag, "_rdata"}, client_rdata, 128'(0));
    check_val({tag, "_fp"}, 128'({fp_pread, fp_pwrite, fp_busy, fp_gid, fp_resp, fp_paddr}), 128'(0));
    check_val({tag, "_fp_data"}, fp_pwdata | fp_rdata_c, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    client_read = '0; client_write = '0; client_address = '0; client_wdata = '0;
    fp_read = '0; fp_write = '0; fp_addr = '0; fp_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0; fp_presp = 1'b0; fp_prdata = '0;
    pending = '{default: 0}; fp_pending = '{default: 0};
    mem_cnt = 0; mem_lat = 4; mem_en = 1'b1; last_rd = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single read, one-cycle issue latency, address frozen after grant
    push(0, 1'b1, 16'h1230, '0);
    req(0, 1'b1, 1'b0, 16'h1230, '0, 1);
    check_val("t1_pre_read", 128'(pmem_read), 128'(0));
    tick();
    check_val("t1_latency", 128'(pmem_read), 128'(1));
    check_val("t1_addr", 128'(pmem_address), 128'(16'h1230));
    client_address[15:0] = 16'hFFFF;
    wait_idle(60);
    check_val("t1_rdata", client_rdata, {16{8'hA5}});

    // 2: single write from client 1
    push(1, 1'b0, 16'h8000, WD2);
    req(1, 1'b0, 1'b1, 16'h8000, WD2, 1);
    wait_idle(60);
    check_val("t2_rdata_kept", client_rdata, {16{8'hA5}});

    // 3a: round-robin alternation between two continuous requesters
    push(0, 1'b1, 16'h0100, '0);
    push(1, 1'b1, 16'h0200, '0);
    push(0, 1'b1, 16'h0100, '0);
    push(1, 1'b1, 16'h0200, '0);
    req(0, 1'b1, 1'b0, 16'h0100, '0, 2);
    req(1, 1'b1, 1'b0, 16'h0200, '0, 2);
    wait_idle(200);

    // 3b: fixed priority starves client 1 while client 0 keeps requesting
    fp_q.push_back(0); fp_q.push_back(0); fp_q.push_back(0); fp_q.push_back(1);
    fp_addr = {16'h0BBB, 16'h0AAA};
    fp_read = 2'b11;
    fp_pending[0] = 3;
    fp_pending[1] = 1;
    wait_idle(200);

    // 4: wrap-around after a grant to client 3
    push(3, 1'b0, 16'h3000, 128'h3333);
    req(3, 1'b0, 1'b1, 16'h3000, 128'h3333, 1);
    wait_idle(60);
    push(0, 1'b1, 16'h0010, '0);
    push(2, 1'b1, 16'h2000, '0);
    push(2, 1'b1, 16'h2000, '0);
    req(0, 1'b1, 1'b0, 16'h0010, '0, 1);
    req(2, 1'b1, 1'b0, 16'h2000, '0, 2);
    wait_idle(200);

    // 5: asynchronous reset while a read is outstanding
    mem_en = 1'b0;
    push(0, 1'b1, 16'h0500, '0);
    req(0, 1'b1, 1'b0, 16'h0500, '0, 1);
    tick(); tick();
    check_val("t5_issue", 128'(pmem_read), 128'(1));
    #2;
    rst_n = 1'b0;
    client_read = '0; client_write = '0; pending = '{default: 0};
    exp_q.delete();
    last_rd = '0;
    #1;
    check_val("t5_async_read", 128'(pmem_read), 128'(0));
    check_val("t5_async_busy", 128'(busy), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = '1;
    tick();
    pmem_resp = 1'b0;
    tick(); tick();
    check_val("t5_no_resp", 128'(client_resp), 128'(0));
    check_val("t5_idle", 128'(busy), 128'(0));
    check_val("t5_rdata", client_rdata, 128'(0));
    mem_en = 1'b1;
    mem_cnt = 0;
    push(0, 1'b1, 16'h0600, '0);
    req(0, 1'b1, 1'b0, 16'h0600, '0, 1);
    wait_idle(60);

    // 6: read and write raised together perform a read
    push(0, 1'b1, 16'h0040, 128'hDEAD);
    req(0, 1'b1, 1'b1, 16'h0040, 128'hDEAD, 1);
    wait_idle(60);
    check_val("t6_rdata", client_rdata, mem_data(16'h0040));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Parametrised N-client arbiter between the per-client caches (split I-cache/D-cache and any later line fills) and the single physical-memory port.
- Accepts line-sized read and write requests from NUM_PORTS cache-side clients and grants one client at a time.
- Registers the winning request and drives it to pmem, then returns the response to that client only.
- Generalises the single cache-to-pmem connection to multiple channels, with selectable round-robin or fixed-priority arbitration.

Parameters:
- NUM_PORTS, 2, number of clients; legal range 2..8.
- ADDR_WIDTH, 16, byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- FIXED_PRIORITY, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- client_read  in  NUM_PORTS  per-client read request; held high until that client's client_resp.
- client_write  in  NUM_PORTS  per-client write request; held high until that client's client_resp.
- client_address  in  NUM_PORTS*ADDR_WIDTH  per-client line address; client i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- client_wdata  in  NUM_PORTS*LINE_WIDTH  per-client write line, packed the same way.
- client_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse to the granted client.
- client_rdata  out  LINE_WIDTH  read line, shared by all clients; valid while client_resp is nonzero.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_wdata  out  LINE_WIDTH  physical memory write data.
- pmem_resp  in  1  physical memory completion.
- pmem_rdata  in  LINE_WIDTH  physical memory read data; valid with pmem_resp.
- grant_id  out  clog2(NUM_PORTS)  index of the current or last granted client.
- busy  out  1  high in ISSUE or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata, client_resp, client_rdata, grant_id, busy.
  - Round-robin pointer last = NUM_PORTS-1, so port 0 has first priority.
- Reset mid-transaction: the transaction is abandoned. No client_resp is issued. A pmem_resp arriving after reset deassertion while in IDLE is ignored.
- Request vector: req[i] = client_read[i] | client_write[i].
- If a client raises both read and write, the arbiter performs a read. The write bit is ignored for that transaction.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If req is nonzero at a clock edge, select winner g and register the following: grant_id=g; pmem_address=client g's address; pmem_wdata=client g's wdata; the operation type.
  - Move to ISSUE. pmem_read or pmem_write goes high in the first ISSUE cycle, which is the cycle after the request was sampled.
  - If req is zero, stay in IDLE.
- ISSUE:
  - Hold the strobe, address and wdata stable until pmem_resp=1.
  - On the edge where pmem_resp=1: capture pmem_rdata into client_rdata, deassert the pmem strobe, set client_resp[g]=1 and move to DONE.
  - Duration of ISSUE is unbounded; there is no timeout.
- DONE:
  - Exactly one cycle with client_resp one-hot at g.
  - Next edge: clear client_resp and return to IDLE.
  - client_rdata holds its value until the next read completion. Write completions leave client_rdata unchanged.
- Minimum turnaround is 3 cycles per transaction (IDLE sample, ISSUE, DONE) plus pmem latency.
- The client deasserts its request at the DONE edge, so IDLE never re-grants a stale request.
- Round-robin selection (FIXED_PRIORITY=0):
  - Search indices last+1, last+2, ... modulo NUM_PORTS; the first one with req set wins. The search wraps from NUM_PORTS-1 to 0.
  - last is updated to g on grant.
  - Two clients requesting continuously therefore alternate.
- Fixed priority (FIXED_PRIORITY=1): the lowest set index wins and last is unused. Starvation of higher indices is permitted.
- Requests that arrive or change while in ISSUE or DONE have no effect on the current transaction. They are evaluated at the next IDLE.
- Client inputs are sampled only in IDLE. Changes on the granted client's address or wdata after grant do not reach pmem.
- busy = (state != IDLE).

Test Plan:
1. Single read: client 0 read at address 0x1230; pmem_resp asserted 4 cycles after pmem_read with rdata=0xA5..A5 -> pmem_read high 1 cycle after request, pmem_address=0x1230, client_resp=2'b01 for exactly 1 cycle, client_rdata=0xA5..A5.
2. Single write: client 1 writes wdata=0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to address 0x8000 -> pmem_write=1, pmem_wdata equals that value, pmem_read=0, client_resp=2'b10 once, client_rdata unchanged.
3. Round-robin: clients 0 and 1 request continuously, each re-requesting immediately after its resp -> grant order 0,1,0,1. With FIXED_PRIORITY=1 the order is 0,0,0 and client 1 is never served while client 0 keeps requesting.
4. Wrap-around with NUM_PORTS=4: last=3, requests on clients 0 and 2 -> client 0 granted; then client 2; then with only client 2 still requesting, client 2 is granted again.
5. Reset during ISSUE: rst_n low while pmem_read=1 -> pmem_read=0 and busy=0 immediately (async). A pmem_resp pulse after release produces no client_resp. The next request to client 0 is served normally.
6. Read and write both asserted on client 0 at address 0x0040 -> pmem_read=1, pmem_write=0, client_resp pulses once.
